// File: rtl/hue_pkg.sv
// ---------------------------------------------------------------------------
// hue_pkg : sector encodings and sector-to-duty mapping for hue_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hue_pkg;

  typedef enum logic [2:0] {
    SEC_R_G_UP = 3'd0,
    SEC_R_DN   = 3'd1,
    SEC_B_UP   = 3'd2,
    SEC_G_DN   = 3'd3,
    SEC_R_UP   = 3'd4,
    SEC_B_DN   = 3'd5
  } sector_t;

  localparam int DUTY_CALC_W = 32;

  typedef struct packed {
    logic [DUTY_CALC_W-1:0] r;
    logic [DUTY_CALC_W-1:0] g;
    logic [DUTY_CALC_W-1:0] b;
  } duty3_t;

  function automatic duty3_t sector_duty(input sector_t s,
                                         input logic [DUTY_CALC_W-1:0] r,
                                         input logic [DUTY_CALC_W-1:0] max);
    duty3_t d;
    logic [DUTY_CALC_W-1:0] dn;
    dn = max - r;
    d  = '0;
    case (s)
      SEC_R_G_UP: begin d.r = max; d.g = r;   d.b = '0;  end
      SEC_R_DN:   begin d.r = dn;  d.g = max; d.b = '0;  end
      SEC_B_UP:   begin d.r = '0;  d.g = max; d.b = r;   end
      SEC_G_DN:   begin d.r = '0;  d.g = dn;  d.b = max; end
      SEC_R_UP:   begin d.r = r;   d.g = '0;  d.b = max; end
      SEC_B_DN:   begin d.r = max; d.g = '0;  d.b = dn;  end
      default:    begin d.r = max; d.g = '0;  d.b = '0;  end
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_timer.sv
// ---------------------------------------------------------------------------
// step_timer : enable-gated divider, one-cycle step every TICK_DIV enabled clocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module step_timer #(
  parameter int TICK_DIV = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic step
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_q, tick_d;

  assign step = en && (tick_q == TICK_LAST);

  always_comb begin
    tick_d = tick_q;
    if (en) begin
      tick_d = step ? '0 : tick_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_q <= '0;
    else     tick_q <= tick_d;
  end

endmodule

`default_nettype wire

// File: rtl/hue_sequencer.sv
// ---------------------------------------------------------------------------
// hue_sequencer : six-sector colour wheel, RGB duties committed on PWM wrap
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hue_sequencer
  import hue_pkg::*;
#(
  parameter  int PWM_INTERVAL = 1200,
  parameter  int STEP         = 1,
  parameter  int TICK_DIV     = 2000,
  localparam int W            = $clog2(PWM_INTERVAL + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         period_start,
  output logic [W-1:0] duty_r,
  output logic [W-1:0] duty_g,
  output logic [W-1:0] duty_b,
  output logic [2:0]   sector,
  output logic         update
);

  localparam logic [W-1:0] RAMP_LIMIT = W'(PWM_INTERVAL - STEP);
  localparam logic [W-1:0] RAMP_INC   = W'(STEP);
  localparam logic [W-1:0] FULL_SCALE = W'(PWM_INTERVAL);

  sector_t      sector_q, sector_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] duty_r_q, duty_g_q, duty_b_q;
  logic         update_q;
  logic         step;
  duty3_t       calc;

  step_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .step (step)
  );

  always_comb begin
    sector_d = sector_q;
    r_d      = r_q;
    if (step) begin
      if (r_q >= RAMP_LIMIT) begin
        r_d = '0;
        case (sector_q)
          SEC_R_G_UP: sector_d = SEC_R_DN;
          SEC_R_DN:   sector_d = SEC_B_UP;
          SEC_B_UP:   sector_d = SEC_G_DN;
          SEC_G_DN:   sector_d = SEC_R_UP;
          SEC_R_UP:   sector_d = SEC_B_DN;
          default:    sector_d = SEC_R_G_UP;
        endcase
      end else begin
        r_d = r_q + RAMP_INC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sector_q <= SEC_R_G_UP;
      r_q      <= '0;
    end else begin
      sector_q <= sector_d;
      r_q      <= r_d;
    end
  end

  // Commit samples the pre-step position, so a coincident step lands next period.
  assign calc = sector_duty(sector_q, DUTY_CALC_W'(r_q), DUTY_CALC_W'(PWM_INTERVAL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_r_q <= FULL_SCALE;
      duty_g_q <= '0;
      duty_b_q <= '0;
      update_q <= 1'b0;
    end else begin
      update_q <= period_start;
      if (period_start) begin
        duty_r_q <= W'(calc.r);
        duty_g_q <= W'(calc.g);
        duty_b_q <= W'(calc.b);
      end
    end
  end

  assign duty_r = duty_r_q;
  assign duty_g = duty_g_q;
  assign duty_b = duty_b_q;
  assign sector = sector_q;
  assign update = update_q;

endmodule

`default_nettype wire

// File: tb/tb_hue_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hue_sequencer : scoreboard bench for hue_sequencer against a wheel-position model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hue_sequencer;

  localparam int PI  = 12;
  localparam int ST  = 4;
  localparam int TD  = 3;
  localparam int W   = $clog2(PI + 1);
  localparam int SPS = (PI + ST - 1) / ST;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         period_start;
  logic [W-1:0] duty_r, duty_g, duty_b;
  logic [2:0]   sector;
  logic         update;

  typedef struct {
    int r;
    int g;
    int b;
  } trip_t;

  trip_t q[$];
  trip_t last;
  int    en_cnt;
  int    total = 0;
  int    bad   = 0;

  hue_sequencer #(
    .PWM_INTERVAL (PI),
    .STEP         (ST),
    .TICK_DIV     (TD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .period_start (period_start),
    .duty_r       (duty_r),
    .duty_g       (duty_g),
    .duty_b       (duty_b),
    .sector       (sector),
    .update       (update)
  );

  always #5 clk = ~clk;

  // Wheel position is simply the number of completed steps modulo one revolution.
  function automatic int ref_sector(int steps);
    return (steps % (6 * SPS)) / SPS;
  endfunction

  function automatic trip_t ref_duty(int steps);
    trip_t t;
    int    up;
    int    dn;
    up = ((steps % (6 * SPS)) % SPS) * ST;
    dn = PI - up;
    case (ref_sector(steps))
      0:       begin t.r = PI; t.g = up; t.b = 0;  end
      1:       begin t.r = dn; t.g = PI; t.b = 0;  end
      2:       begin t.r = 0;  t.g = PI; t.b = up; end
      3:       begin t.r = 0;  t.g = dn; t.b = PI; end
      4:       begin t.r = up; t.g = 0;  t.b = PI; end
      default: begin t.r = PI; t.g = 0;  t.b = dn; end
    endcase
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      if (period_start) q.push_back(ref_duty(en_cnt / TD));
      if (en) en_cnt++;
    end
  end

  always @(negedge clk) begin : monitor
    trip_t e;
    int    exp_upd;
    exp_upd = (q.size() != 0) ? 1 : 0;
    if (exp_upd == 1) begin
      e    = q.pop_front();
      last = e;
    end
    check("update", int'(update), exp_upd);
    check("duty_r", int'(duty_r), last.r);
    check("duty_g", int'(duty_g), last.g);
    check("duty_b", int'(duty_b), last.b);
    check("sector", int'(sector), ref_sector(en_cnt / TD));
    if (update) begin
      check("duty_range", int'(duty_r <= PI && duty_g <= PI && duty_b <= PI), 1);
    end
  end

  task automatic drive(input logic e, input logic p);
    @(negedge clk);
    en           = e;
    period_start = p;
  endtask

  task automatic reset_model();
    q.delete();
    en_cnt = 0;
    last.r = PI;
    last.g = 0;
    last.b = 0;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    reset_model();
    #1;
    check("rst_duty_r", int'(duty_r), PI);
    check("rst_duty_g", int'(duty_g), 0);
    check("rst_duty_b", int'(duty_b), 0);
    check("rst_sector", int'(sector), 0);
    check("rst_update", int'(update), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    period_start = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;

    // Ramp start with a commit every cycle, then past the first sector boundary.
    repeat (12) drive(1'b1, 1'b1);

    // More than one full revolution with sparse commits.
    for (int i = 0; i < 60; i++) drive(1'b1, (i % 5) == 0);

    // Frozen wheel: commits keep coming, position must not move.
    for (int i = 0; i < 20; i++) drive(1'b0, (i % 5) == 0);
    repeat (4) drive(1'b1, 1'b1);

    // Commit on the exact cycle a step fires, then right after it.
    for (int k = 0; k < TD && (en_cnt % TD) != TD - 1; k++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);

    // Long gap without commits, then a single commit jumps straight to the position.
    repeat (30) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);

    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);

    mid_reset();
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);

    en           = 1'b1;
    period_start = 1'b1;
    mid_reset();
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);

    repeat (3) drive(1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hue_sequencer.md
# hue_sequencer

Upstream stage of the RGB PWM path. Walks a six-sector colour wheel and produces three channel duty values, `duty_r`, `duty_g` and `duty_b`, for three downstream `pwm` instances. Duties are committed only on the PWM period boundary reported by the downstream stage, so the LEDs never see a mid-period duty change. It replaces the one-channel-at-a-time stepping with continuous, simultaneous three-channel hue rotation.

## Interface
- `PWM_INTERVAL`, default 1200: full-scale duty, equal to the downstream PWM period in clocks.
- `STEP`, default 1: ramp increment per step; legal range 1 ≤ STEP ≤ PWM_INTERVAL.
- `TICK_DIV`, default 2000: clocks per ramp step; must be ≥ 1.
- Derived width `W = $clog2(PWM_INTERVAL+1)`, so full-scale is representable.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable; when 0, the wheel position freezes.
- `period_start`  in  1  one-cycle pulse from the downstream PWM at its counter wrap.
- `duty_r`, `duty_g`, `duty_b`  out  W each  committed duties, in the range 0..PWM_INTERVAL.
- `sector`  out  3  current wheel sector, 0..5.
- `update`  out  1  one-cycle pulse, high in the first cycle new duties are visible.

## Operation
- **Tick divider:** `tick` counts 0..TICK_DIV-1 while `en`=1 and holds while `en`=0. A step fires on the cycle where `tick`=TICK_DIV-1 and `en`=1; `tick` wraps to 0 on that cycle.
- **Ramp register `r`** (W bits), updated on each step:
  - If `r` ≥ PWM_INTERVAL−STEP: `r`←0 and `sector` advances (5→0).
  - Otherwise: `r`←`r`+STEP.
  - Steps per sector = ceil(PWM_INTERVAL/STEP).
- **Sector state machine** (up = `r`, dn = PWM_INTERVAL−`r`, M = PWM_INTERVAL):
  - 0: R=M, G=up, B=0.
  - 1: R=dn, G=M, B=0.
  - 2: R=0, G=M, B=up.
  - 3: R=0, G=dn, B=M.
  - 4: R=up, G=0, B=M.
  - 5: R=M, G=0, B=dn.
- **Commit:** computed duties are combinational from the current (`sector`, `r`) registers. On a clock edge with `period_start`=1, the `duty_*` outputs load the computed values and `update` is set for exactly one cycle.
- **Reset values:** `sector`=0, `r`=0, `tick`=0, `duty_r`=PWM_INTERVAL, `duty_g`=0, `duty_b`=0, `update`=0. These apply immediately and asynchronously, including mid-sector or mid-commit.

## Timing
- **Commit latency:** `duty_*` and `update` change on the edge that samples `period_start`=1; one cycle of latency.
- **Step and commit in the same cycle:** the commit uses the pre-step (`sector`, `r`). The new step is committed at the next `period_start`.
- **Multiple steps between commits:** intermediate values are never output; only the position at commit time is.
- **`en` deasserted:** `tick`, `r` and `sector` hold. Commits continue with unchanged values, and `update` still pulses.
- **`period_start` held high:** a commit happens every cycle, and `update` stays high.
- **Wheel period:** 6 × ceil(PWM_INTERVAL/STEP) × TICK_DIV clocks with `en`=1. Defaults give 6 × 1200 × 2000 = 14.4 M clocks (1.2 s at 12 MHz).
- **Sector boundary:** the channel that was ramping up reaches PWM_INTERVAL−STEP at most, then the next sector starts its falling channel at M. The maximum duty jump at a boundary is STEP.

## Structure
- Package `hue_pkg`:
  - `sector_t` enum with six encodings, `SEC_R_G_UP`=0 through `SEC_B_DN`=5.
  - A function `sector_duty(sector_t, r, max)` returning the three duties.
- One sub-module, `step_timer`: parameter TICK_DIV; ports `clk`, `rst`, `en`, `step` (pulse).
- Top level holds `r`, the `sector` FSM and the commit registers. Target is 150–250 lines of RTL total.

## Test plan
Parameters for all tests: PWM_INTERVAL=12, STEP=4, TICK_DIV=3.
- **Reset:** assert `rst` mid-run asynchronously, between edges → duties immediately read 12/0/0, `sector`=0, `update`=0.
- **First step:** `en`=1, `period_start` tied to 1 → `duty_g` follows 0, 4, 8 at 3-clock spacing. On the 9th clock, `sector`=1 and the duties become 12/12/0. `update` stays high throughout.
- **Full wheel:** `en`=1 and `period_start` pulsed every 5 clocks → `sector` returns to 0 after 54 clocks. Every committed triple matches the sector table, and no duty ever exceeds 12.
- **Freeze:** drop `en` for 20 clocks while `period_start` keeps pulsing → `update` pulses and duties stay constant. Resuming `en` continues from the held `tick` value.
- **Coincident step and commit:** align the step cycle with `period_start`=1 → the committed value is the pre-step one, and the next commit shows the post-step value.
- **Commit gating:** hold `period_start`=0 for 30 clocks with `en`=1 → `duty_*` unchanged and `update`=0. On the first `period_start`, the outputs jump directly to the current wheel position.
